// File: rtl/alarm_pkg.sv
// alarm_pkg: shared FSM state, time limits and width helper for the alarm controller
package alarm_pkg;

   typedef enum logic [1:0] {IDLE, RINGING, SNOOZE} state_t;

   localparam logic [5:0] HOUR_MAX     = 6'd23;
   localparam logic [5:0] MIN_MAX      = 6'd59;
   localparam int         SECS_PER_MIN = 60;

   function automatic int w_of(input int n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/alarm_slot.sv
// alarm_slot: one programmable alarm time with write validation and a registered match pulse
module alarm_slot
   import alarm_pkg::*;
(
   input  logic       clk_50MHz,
   input  logic       reset,
   input  logic       tick_1Hz,
   input  logic [5:0] cur_hour,
   input  logic [5:0] cur_min,
   input  logic [5:0] cur_sec,
   input  logic       wr_en,
   input  logic [5:0] wr_hour,
   input  logic [5:0] wr_min,
   input  logic       wr_enable,
   output logic [5:0] slot_hour,
   output logic [5:0] slot_min,
   output logic       slot_en,
   output logic       match
);

   logic [5:0] hour_q, hour_d, min_q, min_d;
   logic       en_q, en_d, match_q, match_d, wr_ok;

   // Take only legal times; flag a match on the top-of-minute tick
   always_comb begin
      wr_ok   = wr_en && wr_hour <= HOUR_MAX && wr_min <= MIN_MAX;
      hour_d  = wr_ok ? wr_hour : hour_q;
      min_d   = wr_ok ? wr_min : min_q;
      en_d    = wr_ok ? wr_enable : en_q;
      match_d = tick_1Hz && cur_sec == 6'd0 && en_q && cur_hour == hour_q && cur_min == min_q;
   end

   // Slot registers
   always_ff @(posedge clk_50MHz or posedge reset) begin
      if (reset) begin
         hour_q  <= '0;
         min_q   <= '0;
         en_q    <= 1'b0;
         match_q <= 1'b0;
      end else begin
         hour_q  <= hour_d;
         min_q   <= min_d;
         en_q    <= en_d;
         match_q <= match_d;
      end
   end

   assign slot_hour = hour_q;
   assign slot_min  = min_q;
   assign slot_en   = en_q;
   assign match     = match_q;

endmodule

// File: rtl/multi_alarm_controller.sv
// multi_alarm_controller: N alarm slots with pending queue, snooze and ring timeout
module multi_alarm_controller
   import alarm_pkg::*;
#(
   parameter  int NUM_ALARMS   = 4,
   parameter  int SNOOZE_MIN   = 5,
   parameter  int MAX_SNOOZE   = 3,
   parameter  int RING_SECONDS = 60,
   localparam int SEL_W        = w_of(NUM_ALARMS)
) (
   input  logic                  clk_50MHz,
   input  logic                  reset,
   input  logic                  tick_1Hz,
   input  logic [5:0]            cur_hour,
   input  logic [5:0]            cur_min,
   input  logic [5:0]            cur_sec,
   input  logic [SEL_W-1:0]      sel,
   input  logic                  wr_en,
   input  logic [5:0]            wr_hour,
   input  logic [5:0]            wr_min,
   input  logic                  wr_enable,
   output logic [5:0]            rd_hour,
   output logic [5:0]            rd_min,
   output logic                  rd_enable,
   input  logic                  key_snooze,
   input  logic                  key_dismiss,
   output logic                  ringing,
   output logic [SEL_W-1:0]      active_slot,
   output logic                  alarm_LED,
   output logic                  snooze_LED,
   output logic [NUM_ALARMS-1:0] pending
);

   localparam int CD_W = w_of(SNOOZE_MIN * SECS_PER_MIN + 1);
   localparam int RC_W = w_of(RING_SECONDS + 1);
   localparam int SC_W = w_of(MAX_SNOOZE + 1);
   localparam logic [CD_W-1:0] CD_LOAD = CD_W'(SNOOZE_MIN * SECS_PER_MIN);
   localparam logic [RC_W-1:0] RC_END  = RC_W'(RING_SECONDS);
   localparam logic [SC_W-1:0] SC_MAX  = SC_W'(MAX_SNOOZE);

   state_t                state_q, state_d;
   logic [CD_W-1:0]       cd_q, cd_d;
   logic [RC_W-1:0]       ring_q, ring_d, ring_inc;
   logic [SC_W-1:0]       snz_q, snz_d;
   logic                  led_q, led_d;
   logic [SEL_W-1:0]      act_q, act_d, pick;
   logic [NUM_ALARMS-1:0] pend_q, pend_d, pend_all, match_a, sel_oh, en_a;
   logic [5:0]            hour_a [NUM_ALARMS];
   logic [5:0]            min_a  [NUM_ALARMS];
   logic                  sel_ok, wr_ok, abort;

   for (genvar i = 0; i < NUM_ALARMS; i++) begin : g_slot
      assign sel_oh[i] = int'(sel) == i;
      alarm_slot u_slot (
         .clk_50MHz (clk_50MHz),
         .reset     (reset),
         .tick_1Hz  (tick_1Hz),
         .cur_hour  (cur_hour),
         .cur_min   (cur_min),
         .cur_sec   (cur_sec),
         .wr_en     (wr_en && sel_oh[i]),
         .wr_hour   (wr_hour),
         .wr_min    (wr_min),
         .wr_enable (wr_enable),
         .slot_hour (hour_a[i]),
         .slot_min  (min_a[i]),
         .slot_en   (en_a[i]),
         .match     (match_a[i])
      );
   end

   assign sel_ok    = int'(sel) < NUM_ALARMS;
   assign wr_ok     = wr_en && sel_ok && wr_hour <= HOUR_MAX && wr_min <= MIN_MAX;
   assign abort     = wr_ok && !wr_enable && sel == act_q && state_q != IDLE;
   assign rd_hour   = sel_ok ? hour_a[sel] : '0;
   assign rd_min    = sel_ok ? min_a[sel] : '0;
   assign rd_enable = sel_ok && en_a[sel];
   // Fresh match pulses show up in pending the cycle after the tick, before they are latched
   assign pend_all  = pend_q | match_a;

   // Lowest-index pending slot is serviced first
   always_comb begin
      pick = '0;
      for (int k = NUM_ALARMS - 1; k >= 0; k--) pick = pend_all[k] ? SEL_W'(k) : pick;
   end

   // Next state: abort beats keys, dismiss beats snooze, keys beat the tick
   always_comb begin
      state_d  = state_q;
      cd_d     = cd_q;
      ring_d   = ring_q;
      snz_d    = snz_q;
      led_d    = led_q;
      act_d    = act_q;
      pend_d   = pend_all;
      ring_inc = ring_q + RC_W'(1);
      unique case (state_q)
         IDLE:
            if (|pend_all) begin
               state_d      = RINGING;
               act_d        = pick;
               pend_d[pick] = 1'b0;
               ring_d       = '0;
               snz_d        = '0;
               led_d        = 1'b1;
            end
         RINGING:
            if (abort || key_dismiss || (key_snooze && snz_q == SC_MAX)) begin
               state_d = IDLE;
               led_d   = 1'b0;
            end else if (key_snooze) begin
               state_d = SNOOZE;
               snz_d   = snz_q + SC_W'(1);
               cd_d    = CD_LOAD;
               led_d   = 1'b0;
            end else if (tick_1Hz) begin
               ring_d = ring_inc;
               led_d  = ring_inc == RC_END ? 1'b0 : ~led_q;
               if (ring_inc == RC_END) state_d = IDLE;
            end
         SNOOZE:
            if (abort || key_dismiss) state_d = IDLE;
            else if (tick_1Hz) begin
               cd_d = cd_q - CD_W'(1);
               if (cd_q == CD_W'(1)) begin
                  state_d = RINGING;
                  ring_d  = '0;
                  led_d   = 1'b1;
               end
            end
         default: state_d = IDLE;
      endcase
      if (abort) pend_d[sel] = 1'b0;
   end

   // State and counter registers
   always_ff @(posedge clk_50MHz or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cd_q    <= '0;
         ring_q  <= '0;
         snz_q   <= '0;
         led_q   <= 1'b0;
         act_q   <= '0;
         pend_q  <= '0;
      end else begin
         state_q <= state_d;
         cd_q    <= cd_d;
         ring_q  <= ring_d;
         snz_q   <= snz_d;
         led_q   <= led_d;
         act_q   <= act_d;
         pend_q  <= pend_d;
      end
   end

   assign ringing     = state_q == RINGING;
   assign snooze_LED  = state_q == SNOOZE;
   assign alarm_LED   = led_q;
   assign active_slot = act_q;
   assign pending     = pend_all;

endmodule

// File: tb/tb_multi_alarm_controller.sv
// tb_multi_alarm_controller: directed scoreboard bench for the multi-slot alarm controller
module tb_multi_alarm_controller;

   logic       clk_50MHz = 1'b0;
   logic       reset, tick_1Hz, wr_en, wr_enable, key_snooze, key_dismiss;
   logic [5:0] cur_hour, cur_min, cur_sec, wr_hour, wr_min, rd_hour, rd_min;
   logic [1:0] sel, active_slot;
   logic       rd_enable, ringing, alarm_LED, snooze_LED;
   logic [3:0] pending;

   typedef struct {
      string       tag;
      logic [31:0] val;
   } exp_t;

   exp_t sb[$];
   int   passed = 0;
   int   total  = 0;
   int   got;

   multi_alarm_controller dut (
      .clk_50MHz   (clk_50MHz),
      .reset       (reset),
      .tick_1Hz    (tick_1Hz),
      .cur_hour    (cur_hour),
      .cur_min     (cur_min),
      .cur_sec     (cur_sec),
      .sel         (sel),
      .wr_en       (wr_en),
      .wr_hour     (wr_hour),
      .wr_min      (wr_min),
      .wr_enable   (wr_enable),
      .rd_hour     (rd_hour),
      .rd_min      (rd_min),
      .rd_enable   (rd_enable),
      .key_snooze  (key_snooze),
      .key_dismiss (key_dismiss),
      .ringing     (ringing),
      .active_slot (active_slot),
      .alarm_LED   (alarm_LED),
      .snooze_LED  (snooze_LED),
      .pending     (pending)
   );

   always #10 clk_50MHz = ~clk_50MHz;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic push(input string t, input logic [31:0] v);
      sb.push_back('{t, v});
   endtask

   task automatic chk(input logic [31:0] obs);
      exp_t e;
      total++;
      if (sb.size() == 0) begin
         $error("FAIL scoreboard_empty: observed %0d expected nothing", obs);
         return;
      end
      e = sb.pop_front();
      assert (obs === e.val) passed++;
      else $error("FAIL %s: observed %0d expected %0d", e.tag, obs, e.val);
   endtask

   task automatic cyc();
      @(posedge clk_50MHz);
      #1;
   endtask

   task automatic tick();
      tick_1Hz = 1'b1;
      cyc();
      tick_1Hz = 1'b0;
   endtask

   task automatic set_time(input int h, input int m, input int s);
      cur_hour = 6'(h);
      cur_min  = 6'(m);
      cur_sec  = 6'(s);
   endtask

   task automatic write(input int s, input int h, input int m, input logic e);
      sel       = 2'(s);
      wr_hour   = 6'(h);
      wr_min    = 6'(m);
      wr_enable = e;
      wr_en     = 1'b1;
      cyc();
      wr_en     = 1'b0;
   endtask

   task automatic key(input logic s, input logic d);
      key_snooze  = s;
      key_dismiss = d;
      cyc();
      key_snooze  = 1'b0;
      key_dismiss = 1'b0;
   endtask

   initial begin
      reset = 1'b1; tick_1Hz = 1'b0; wr_en = 1'b0; wr_enable = 1'b0;
      key_snooze = 1'b0; key_dismiss = 1'b0; sel = '0; wr_hour = '0; wr_min = '0;
      set_time(0, 0, 1);
      repeat (2) cyc();
      reset = 1'b0;
      cyc();
      push("rst_ringing", 0); push("rst_alarm_led", 0); push("rst_snooze_led", 0); push("rst_pending", 0);
      push("rst_active", 0); push("rst_rd_hour", 0); push("rst_rd_min", 0); push("rst_rd_enable", 0);
      chk(ringing); chk(alarm_LED); chk(snooze_LED); chk(pending);
      chk(active_slot); chk(rd_hour); chk(rd_min); chk(rd_enable);

      // slot 2 at 07:30 rings two cycles after the matching tick
      push("wr_rd_hour", 7); push("wr_rd_min", 30); push("wr_rd_enable", 1);
      write(2, 7, 30, 1'b1);
      chk(rd_hour); chk(rd_min); chk(rd_enable);
      set_time(7, 29, 0);
      push("no_match_pending", 0);
      tick();
      chk(pending);
      set_time(7, 30, 0);
      push("match_pending", 4); push("not_yet_ringing", 0);
      tick();
      chk(pending); chk(ringing);
      cur_sec = 6'd1;
      push("ring_on", 1); push("ring_active", 2); push("ring_led_on", 1); push("ring_pend_clr", 0);
      cyc();
      chk(ringing); chk(active_slot); chk(alarm_LED); chk(pending);
      push("blink_off", 0);
      tick();
      chk(alarm_LED);
      push("blink_on", 1);
      tick();
      chk(alarm_LED);

      // three snoozes of exactly 300 ticks, fourth snooze dismisses
      for (int s = 1; s <= 3; s++) begin
         push("snooze_led_on", 1); push("snooze_ring_off", 0);
         key(1'b1, 1'b0);
         chk(snooze_LED); chk(ringing);
         push("snooze_ticks", 300); push("resume_led", 1);
         got = 0;
         for (int n = 1; n <= 400 && got == 0; n++) begin
            tick();
            if (ringing) got = n;
         end
         chk(got); chk(alarm_LED);
      end
      push("snooze4_ring_off", 0); push("snooze4_snooze_off", 0); push("snooze4_led_off", 0);
      key(1'b1, 1'b0);
      chk(ringing); chk(snooze_LED); chk(alarm_LED);

      // two slots match the same tick, serviced in index order
      write(0, 6, 0, 1'b1);
      write(3, 6, 0, 1'b1);
      set_time(6, 0, 0);
      push("dual_pending", 9);
      tick();
      chk(pending);
      cur_sec = 6'd1;
      push("dual_ring", 1); push("dual_active0", 0); push("dual_pend3", 8);
      cyc();
      chk(ringing); chk(active_slot); chk(pending);
      push("dismiss_off", 0);
      key(1'b0, 1'b1);
      chk(ringing);
      push("next_ring", 1); push("next_active3", 3); push("next_pend0", 0);
      cyc();
      chk(ringing); chk(active_slot); chk(pending);

      // unattended ring auto-dismisses on the 60th tick
      repeat (59) tick();
      push("tick59_still_ringing", 1);
      chk(ringing);
      push("tick60_ring_off", 0); push("tick60_led_off", 0);
      tick();
      chk(ringing); chk(alarm_LED);

      // dismiss beats snooze in the same cycle
      set_time(6, 0, 0);
      push("rematch_pending", 9);
      tick();
      chk(pending);
      cur_sec = 6'd1;
      push("rematch_ring", 1); push("rematch_active", 0);
      cyc();
      chk(ringing); chk(active_slot);
      push("both_keys_ring_off", 0); push("both_keys_snooze_off", 0); push("both_keys_pend", 8);
      key(1'b1, 1'b1);
      chk(ringing); chk(snooze_LED); chk(pending);
      push("slot3_ring", 1); push("slot3_active", 3);
      cyc();
      chk(ringing); chk(active_slot);

      // disabling the snoozing slot aborts to idle
      push("abort_pre_snooze", 1);
      key(1'b1, 1'b0);
      chk(snooze_LED);
      push("abort_snooze_off", 0); push("abort_ring_off", 0);
      write(3, 6, 0, 1'b0);
      chk(snooze_LED); chk(ringing);
      push("abort_stays_idle", 0); push("abort_pend", 0); push("abort_rd_enable", 0);
      cyc();
      chk(ringing); chk(pending); chk(rd_enable);

      // out-of-range writes are ignored, 23:59 is accepted
      push("bad_hour_rd_hour", 0); push("bad_hour_rd_enable", 0);
      write(1, 24, 10, 1'b1);
      chk(rd_hour); chk(rd_enable);
      push("bad_min_rd_min", 0); push("bad_min_rd_enable", 0);
      write(1, 5, 60, 1'b1);
      chk(rd_min); chk(rd_enable);
      push("max_rd_hour", 23); push("max_rd_min", 59); push("max_rd_enable", 1);
      write(1, 23, 59, 1'b1);
      chk(rd_hour); chk(rd_min); chk(rd_enable);

      // asynchronous reset in the middle of a ring
      write(2, 6, 0, 1'b1);
      set_time(6, 0, 0);
      push("pre_reset_pending", 5);
      tick();
      chk(pending);
      cur_sec = 6'd1;
      push("pre_reset_ring", 1); push("pre_reset_pend", 4);
      cyc();
      chk(ringing); chk(pending);
      #5;
      reset = 1'b1;
      #1;
      push("async_ring_off", 0); push("async_led_off", 0); push("async_pend_clr", 0); push("async_active", 0);
      chk(ringing); chk(alarm_LED); chk(pending); chk(active_slot);
      sel = 2'd2;
      #1;
      push("async_rd_hour", 0); push("async_rd_min", 0); push("async_rd_enable", 0);
      chk(rd_hour); chk(rd_min); chk(rd_enable);
      cyc();
      reset = 1'b0;
      cyc();
      push("post_reset_idle", 0);
      chk(ringing);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/multi_alarm_controller.md
Name: multi_alarm_controller

Overview:
- Parametrised successor to the single-slot alarm set/enable pair: NUM_ALARMS independently programmable alarm slots, with snooze, ring timeout and a pending queue.
- Sits beside the real-time clock in the clock top.
- Consumes the RTC hour/min/sec counters and the 1 Hz strobe.
- Drives alarm/snooze LEDs and exposes slot readback for the 7-segment and LCD paths.

Parameters:
- NUM_ALARMS, 4, number of alarm slots (1..16).
- SNOOZE_MIN, 5, snooze duration in minutes (1..30).
- MAX_SNOOZE, 3, snoozes allowed per ring event; further snooze presses act as dismiss.
- RING_SECONDS, 60, seconds of unattended ringing before auto-dismiss (1..255).

Ports:
- clk_50MHz  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- tick_1Hz  in  1  one-cycle strobe, once per second, aligned with RTC update
- cur_hour  in  6  RTC hour, 0..23
- cur_min  in  6  RTC minute, 0..59
- cur_sec  in  6  RTC second, 0..59
- sel  in  SEL_W  slot index for write and readback; SEL_W = max(1, clog2(NUM_ALARMS))
- wr_en  in  1  one-cycle write strobe
- wr_hour  in  6  slot hour to write
- wr_min  in  6  slot minute to write
- wr_enable  in  1  slot enable to write
- rd_hour  out  6  hour of slot[sel], combinational
- rd_min  out  6  minute of slot[sel], combinational
- rd_enable  out  1  enable of slot[sel], combinational
- key_snooze  in  1  one-cycle pulse, debounced upstream
- key_dismiss  in  1  one-cycle pulse, debounced upstream
- ringing  out  1  high in RINGING
- active_slot  out  SEL_W  slot currently ringing or snoozed
- alarm_LED  out  1  blinks at 0.5 Hz while ringing
- snooze_LED  out  1  high in SNOOZE
- pending  out  NUM_ALARMS  queued triggers not yet serviced

Behaviour:
- Reset (async, clears immediately): all slots 00:00 and disabled; pending=0; FSM=IDLE; ringing, alarm_LED and snooze_LED =0; active_slot=0; all counters 0.
- Write:
  - On wr_en, slot[sel] takes wr_hour, wr_min and wr_enable.
  - Ignored if wr_hour>23, wr_min>59 or sel>=NUM_ALARMS.
  - A write of wr_enable=0 to active_slot while in RINGING or SNOOZE aborts to IDLE next cycle and clears pending[sel].
- Match:
  - In a cycle with tick_1Hz=1, cur_sec==0, slot enabled and hour/min equal, pending[i] sets. It is visible the next cycle.
  - Multiple slots may set in the same tick.
- FSM states: IDLE, RINGING, SNOOZE.
- IDLE:
  - If pending!=0, go to RINGING one cycle later.
  - active_slot = lowest set index; that pending bit clears.
  - ring_cnt=0; snooze_cnt=0; alarm_LED=1.
  - Worst-case latency from the matching tick to ringing=1 is 2 clk_50MHz cycles.
- RINGING:
  - alarm_LED toggles on each tick_1Hz.
  - ring_cnt increments on each tick_1Hz.
  - key_dismiss goes to IDLE.
  - key_snooze with snooze_cnt<MAX_SNOOZE goes to SNOOZE: snooze_cnt++, countdown loaded with SNOOZE_MIN*60.
  - key_snooze with snooze_cnt==MAX_SNOOZE is treated as dismiss.
  - When ring_cnt reaches RING_SECONDS, auto-dismiss to IDLE.
- SNOOZE:
  - Countdown decrements on each tick_1Hz.
  - At the tick where it reaches 0, go to RINGING: ring_cnt=0, alarm_LED=1, snooze_cnt retained.
  - key_dismiss goes to IDLE. key_snooze is ignored.
- Priorities:
  - key_dismiss beats key_snooze in the same cycle.
  - A key pulse beats a same-cycle tick; the tick's count or timeout effect is discarded.
  - Abort-by-write beats both keys.
- Matches arriving during RINGING or SNOOZE only set pending. They are serviced in index order after return to IDLE; no pre-emption.
- A pending bit that is already set stays set on a re-match; there is no counting.
- Leaving RINGING or SNOOZE for IDLE drops ringing, alarm_LED and snooze_LED on the same edge.
- Counter widths:
  - countdown: clog2(SNOOZE_MIN*60+1).
  - ring_cnt: clog2(RING_SECONDS+1).
  - snooze_cnt: clog2(MAX_SNOOZE+1).
  - No wrap is possible inside legal parameter ranges.

Decomposition:
- Package alarm_pkg:
  - FSM state enum.
  - Constants HOUR_MAX=23, MIN_MAX=59, SECS_PER_MIN=60.
  - SEL_W function.
- Sub-module alarm_slot, instantiated NUM_ALARMS times:
  - Holds hour/min/enable registers with write validation.
  - Produces a registered match pulse.
- The top holds the pending vector, priority picker, FSM and counters.

Test Plan:
- Program slot2=07:30 enabled, RTC reaches 07:30:00 tick -> pending[2] next cycle; ringing=1, active_slot=2 two cycles after the tick; alarm_LED toggles each tick.
- Ringing, key_snooze -> snooze_LED=1; after exactly 300 ticks (SNOOZE_MIN=5) ringing=1 again; 4th key_snooze -> IDLE.
- Slots 0 and 3 both 06:00 -> slot0 rings; dismiss -> slot3 rings 2 cycles later; pending returns to 0.
- Ringing unattended -> ringing=0 on the 60th tick; key_snooze+key_dismiss in the same cycle -> IDLE, not SNOOZE.
- Write wr_hour=24 or wr_min=60 -> rd values unchanged; write wr_enable=0 to the snoozing slot -> IDLE next cycle.
- Assert reset mid-RINGING between clock edges -> ringing, alarm_LED and pending cleared immediately; slots read 00:00 disabled.
